event_encoder_83: RTL
=====================

# event_encoder_83

Registered 8-to-3 event encoder: the producer-side counterpart of the 3-to-8 one-hot decoder. It captures single-cycle events on eight request lines into a sticky pending register and emits them one at a time as 3-bit indices over a valid/ready handshake, in fixed priority order. The downstream consumer typically feeds the index straight into a 3-to-8 decoder to regenerate the one-hot line.

## Interface
- LSB_FIRST, default 1; 1 = lowest set index wins, 0 = highest set index wins.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  8  event strobes; any bit high at an edge sets the corresponding pending bit.
- clr  in  1  synchronous clear of pending and overflow.
- out_valid  out  1  out_code holds an undelivered index.
- out_code  out  3  encoded index (binary, 0..7) of the event being offered.
- out_ready  in  1  consumer accepts out_code when high with out_valid.
- pending  out  8  current pending register (not including the index held in the output stage).
- overflow  out  1  sticky; an event arrived on a bit that was already pending.

## Operation
- Output stage FSM, two states:
  - IDLE: out_valid=0.
  - HOLD: out_valid=1.
- Winner = highest-priority set bit of pending per LSB_FIRST.
- IDLE -> HOLD when pending != 0. The winner index is loaded into out_code, and that bit is cleared from pending at the same edge.
- In HOLD, while out_ready=0: out_valid and out_code are held stable; pending keeps accumulating. Valid is never withdrawn, including on clr.
- HOLD with out_ready=1 (accept):
  - If pending != 0 at that edge, load the next winner and stay in HOLD. This gives back-to-back throughput of one index per cycle.
  - Else go to IDLE.
- Pending update per edge, in order:
  - Start from pending, or from 0 if clr=1.
  - Clear the bit being loaded into out_code this edge.
  - OR in req.
  - Result: a req on the bit being loaded re-pends it, so the set wins. A req coinciding with clr is retained.
- Overflow:
  - Set when req[i]=1 and pending[i]=1 and bit i is not being loaded this edge.
  - Cleared only by clr or rst. If clr and a new overflow condition coincide, clr wins and overflow ends at 0.
- An index already in the output stage is not counted as pending. A new req on that bit re-pends it without overflow.

## Timing
- Reset (async assert, any time, including mid-handshake): pending=0, out_valid=0, out_code=3'b000, overflow=0, FSM=IDLE. Deassertion takes effect at the first clock edge after release.
- Latency from a req pulse sampled at edge E (output stage idle):
  - pending bit visible after E;
  - out_valid=1 with its code after E+1.
  - Total: 2 edges.
- Accept occurs at an edge where out_valid=1 and out_ready=1.
- The next index is valid immediately after the accepting edge if pending was nonzero at that edge; otherwise out_valid drops.
- All outputs are registered; there is no combinational path from req or out_ready to any output.

## Test plan
- Reset/idle: assert rst mid-HOLD with pending=8'h0F -> all outputs 0 immediately, before the next edge. After release with no req, out_valid stays 0.
- Priority order, LSB_FIRST=1: pulse req=8'b1010_0100 for one cycle, out_ready=1 -> out_code sequence 2,5,7 on consecutive cycles, then out_valid=0. With LSB_FIRST=0 -> 7,5,2.
- Backpressure: hold out_ready=0 for 5 cycles with req=8'h81 pulsed -> out_code=0 stable, pending=8'h80. Then raise out_ready -> 0 then 7 accepted on consecutive edges.
- Overflow: pulse req[3] twice while out_ready=0 and bit 0 is held in the output stage -> overflow=1 after the second pulse. Pulse clr -> overflow=0, pending=0, out_valid stays 1 with code 0.
- Collision at load: from IDLE with pending=8'h10 and req[4]=1 at the load edge -> out_code=4 and pending=8'h10 again, overflow=0. After accept, code 4 appears a second time.
- Round trip: drive out_code into a 3-to-8 decoder and pulse each single req bit 0..7 -> decoded one-hot output equals the req pattern, with 2-edge latency each.

Source files
------------

// File: rtl/event_encoder_83.sv
// event_encoder_83
//   Registered 8-to-3 event encoder. It captures single-cycle strobes on eight
//   request lines into a sticky pending register. It then offers them one at a
//   time as binary indices over a valid/ready handshake, in fixed priority
//   order.
//
// Parameters
//   LSB_FIRST  1 = lowest set pending index wins, 0 = highest set index wins.
//
// Ports
//   clk        in   1  clock, rising edge
//   rst        in   1  asynchronous active-high reset
//   req        in   8  event strobes, OR-ed into pending each edge
//   clr        in   1  synchronous clear of pending and overflow
//   out_valid  out  1  out_code holds an undelivered index
//   out_code   out  3  index offered to the consumer
//   out_ready  in   1  consumer accepts when high together with out_valid
//   pending    out  8  pending events, excluding the one in the output stage
//   overflow   out  1  sticky: an event hit a bit that was already pending
module event_encoder_83 #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       clr,
  output logic       out_valid,
  output logic [2:0] out_code,
  input  logic       out_ready,
  output logic [7:0] pending,
  output logic       overflow
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       load;
  logic [2:0] winner;
  logic [7:0] load_mask;
  logic [7:0] pending_next;
  logic       overflow_next;

  // Priority pick: scan so that the preferred end is visited last and overrides.
  always_comb begin
    winner = '0;
    if (LSB_FIRST) begin
      for (int unsigned i = 8; i > 0; i--) begin
        if (pending[i-1]) winner = 3'(i - 1);
      end
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (pending[i]) winner = 3'(i);
      end
    end
  end

  // Output-stage next state. A load happens whenever the stage is empty or
  // is being emptied this edge, and there is something pending.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        if (pending != '0) begin
          load       = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (pending != '0) load = 1'b1;
          else               state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The loaded bit is removed before req is OR-ed in, so a req on that same bit
  // re-pends it. The loaded bit is also excluded from overflow detection.
  always_comb begin
    load_mask     = load ? (8'd1 << winner) : '0;
    pending_next  = ((clr ? '0 : pending) & ~load_mask) | req;
    overflow_next = clr ? 1'b0 : (overflow | (|(req & pending & ~load_mask)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      overflow <= 1'b0;
      out_code <= '0;
    end else begin
      pending  <= pending_next;
      overflow <= overflow_next;
      if (load) out_code <= winner;
    end
  end

  assign out_valid = (state == HOLD);

endmodule
